reg_write_ctrl: RTL and testbench

Write-side front end for the 32 x 32-bit register file. Accepts writeback requests from the ALU/load path and from the jump-and-link path, buffers them, and issues at most one register write per cycle on the register file's write interface (`RegWrite`, `RDaddr`, `RDdata`). Owns all writes to the link register, so the register file sees a single, ordered write stream.

---
 rtl/reg_wb_pkg.sv | 17 +
 rtl/wb_fifo.sv | 76 +++++++
 rtl/reg_write_ctrl.sv | 156 +++++++++++++++
 tb/tb_reg_write_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register-file write path.
// Optional feature macro used by this slice: REG_WRITE_CTRL_FORWARD_EN.
package reg_wb_pkg;

  localparam int ADDR_W    = 5;
  localparam int WB_DATA_W = 32;

  localparam logic [ADDR_W-1:0] LINK_REG = 5'd31;

  // One pending register write. The data field width is fixed at WB_DATA_W,
  // so the top-level DATA_W must be set to the same value.
  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO of write requests.
// With REG_WRITE_CTRL_FORWARD_EN defined, the storage array and the write
// pointer are exported so the parent can search pending writes.
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  wb_req_t          push_req_i,
  input  logic             pop_i,
  output wb_req_t          head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
`ifdef REG_WRITE_CTRL_FORWARD_EN
  ,
  output wb_req_t          entries_o [DEPTH],
  output logic [PTR_W-1:0] wr_ptr_o
`endif
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Self-protect against overflow and underflow.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

`ifdef REG_WRITE_CTRL_FORWARD_EN
  assign entries_o = mem_q;
  assign wr_ptr_o  = wr_ptr_q;
`endif

  // Pointer and occupancy next-state; pointers wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push && !do_pop) count_d = count_q + CNT_ONE;
    if (!do_push && do_pop) count_d = count_q - CNT_ONE;
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_req_i;
    end
  end

endmodule

// File: rtl/reg_write_ctrl.sv
// Write-side front end of the register file: merges ALU and link writeback
// requests into one registered write stream (RegWrite_o/RDaddr_o/RDdata_o).
// A pending link write always wins the issue slot over the ALU FIFO head.
// Define REG_WRITE_CTRL_FORWARD_EN to add the combinational forwarding
// search (fwd_addr_i / fwd_hit_o / fwd_data_o).
// DATA_W must equal reg_wb_pkg::WB_DATA_W.
module reg_write_ctrl
  import reg_wb_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] LINK_REG = reg_wb_pkg::LINK_REG
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_addr_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              alu_ready_o,
  input  logic              link_valid_i,
  input  logic [DATA_W-1:0] link_data_i,
  output logic              link_ready_o,
  output logic              RegWrite_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] RDdata_o
`ifdef REG_WRITE_CTRL_FORWARD_EN
  ,
  input  logic [ADDR_W-1:0] fwd_addr_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic              link_vld_q, link_vld_d;
  logic [DATA_W-1:0] link_data_q, link_data_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  wb_req_t           push_req, fifo_head;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PTR_W:0]    fifo_count;
  logic              link_accept;

`ifdef REG_WRITE_CTRL_FORWARD_EN
  wb_req_t           fifo_entries [DEPTH];
  logic [PTR_W-1:0]  fifo_wr_ptr;
`endif

  // Readiness depends only on stored state: no pop-through on a full FIFO.
  assign alu_ready_o  = (fifo_count < CNT_FULL);
  assign link_ready_o = !link_vld_q;

  // Writes to r0 are accepted but never stored.
  assign fifo_push   = alu_valid_i && !fifo_full && (alu_addr_i != '0);
  assign push_req    = '{addr: alu_addr_i, data: alu_data_i};
  assign link_accept = link_valid_i && link_ready_o && (LINK_REG != '0);
  assign fifo_pop    = !link_vld_q && !fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (fifo_push),
    .push_req_i (push_req),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
`ifdef REG_WRITE_CTRL_FORWARD_EN
    ,
    .entries_o  (fifo_entries),
    .wr_ptr_o   (fifo_wr_ptr)
`endif
  );

  // Issue arbitration and link holding register next-state.
  always_comb begin
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    link_vld_d  = link_vld_q;
    link_data_d = link_data_q;
    if (link_vld_q) begin
      we_d       = 1'b1;
      addr_d     = LINK_REG;
      data_d     = link_data_q;
      link_vld_d = 1'b0;
    end else if (!fifo_empty) begin
      we_d   = 1'b1;
      addr_d = fifo_head.addr;
      data_d = fifo_head.data;
    end
    if (link_accept) begin
      link_vld_d  = 1'b1;
      link_data_d = link_data_i;
    end
  end

  // Output and holding registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      link_vld_q  <= 1'b0;
      link_data_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      link_vld_q  <= link_vld_d;
      link_data_q <= link_data_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign RegWrite_o = we_q;
  assign RDaddr_o   = addr_q;
  assign RDdata_o   = data_q;

`ifdef REG_WRITE_CTRL_FORWARD_EN
  logic [PTR_W-1:0] srch_idx;
  logic             found;

  // Youngest-first search: holding register, FIFO (newest to oldest), output.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    found      = 1'b0;
    srch_idx   = '0;
    if (fwd_addr_i != '0) begin
      if (link_vld_q && (fwd_addr_i == LINK_REG)) begin
        found      = 1'b1;
        fwd_data_o = link_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        srch_idx = fifo_wr_ptr - PTR_W'(i + 1);
        if (!found && ((PTR_W + 1)'(i) < fifo_count) &&
            (fifo_entries[srch_idx].addr == fwd_addr_i)) begin
          found      = 1'b1;
          fwd_data_o = fifo_entries[srch_idx].data;
        end
      end
      if (!found && we_q && (addr_q == fwd_addr_i)) begin
        found      = 1'b1;
        fwd_data_o = data_q;
      end
      fwd_hit_o = found;
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Self-checking bench for reg_write_ctrl (forwarding checks compiled only
// when REG_WRITE_CTRL_FORWARD_EN is defined).
module tb_reg_write_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        link_valid = 1'b0;
  logic [31:0] link_data = '0;
  logic        alu_ready, link_ready, reg_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
`ifdef REG_WRITE_CTRL_FORWARD_EN
  logic [4:0]  fwd_addr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  // Model: queue of pending ALU writes, one link slot, last issued write.
  logic [4:0]  qa [$];
  logic [31:0] qd [$];
  bit          lp;
  logic [31:0] ld;
  bit          ew;
  logic [4:0]  ea;
  logic [31:0] ed;
  bit          alu_acc, link_acc;

  reg_write_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .alu_valid_i  (alu_valid),
    .alu_addr_i   (alu_addr),
    .alu_data_i   (alu_data),
    .alu_ready_o  (alu_ready),
    .link_valid_i (link_valid),
    .link_data_i  (link_data),
    .link_ready_o (link_ready),
    .RegWrite_o   (reg_write),
    .RDaddr_o     (rd_addr),
    .RDdata_o     (rd_data)
`ifdef REG_WRITE_CTRL_FORWARD_EN
    ,
    .fwd_addr_i   (fwd_addr),
    .fwd_hit_o    (fwd_hit),
    .fwd_data_o   (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    qa.delete(); qd.delete();
    lp = 0; ld = '0; ew = 0; ea = '0; ed = '0;
    alu_acc = 0; link_acc = 0;
  endtask

  // One rising edge: apply the spec rules to the model, then step off the edge.
  task automatic tick();
    bit ar, lr;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      ar = (qa.size() < DEPTH);
      lr = !lp;
      alu_acc  = alu_valid && ar;
      link_acc = link_valid && lr;
      if (lp) begin
        ew = 1; ea = 5'd31; ed = ld; lp = 0;
      end else if (qa.size() > 0) begin
        ew = 1; ea = qa.pop_front(); ed = qd.pop_front();
      end else begin
        ew = 0;
      end
      if (alu_acc && alu_addr != 5'd0) begin
        qa.push_back(alu_addr); qd.push_back(alu_data);
      end
      if (link_acc) begin
        lp = 1; ld = link_data;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; alu_valid = 0; link_valid = 0;
    model_clear();
    #1;
    tick();
    rst = 1'b0;
  endtask

`ifdef REG_WRITE_CTRL_FORWARD_EN
  function automatic logic [32:0] fwd_model(input logic [4:0] a);
    if (a == 5'd0) return '0;
    if (lp && a == 5'd31) return {1'b1, ld};
    for (int i = qa.size() - 1; i >= 0; i--)
      if (qa[i] == a) return {1'b1, qd[i]};
    if (ew && ea == a) return {1'b1, ed};
    return '0;
  endfunction
`endif

  // Cycle-by-cycle comparison against the model on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        chk("RegWrite", 64'(reg_write), 64'(ew));
        chk("RDaddr", 64'(rd_addr), 64'(ea));
        chk("RDdata", 64'(rd_data), 64'(ed));
        chk("alu_ready", 64'(alu_ready), 64'(qa.size() < DEPTH));
        chk("link_ready", 64'(link_ready), 64'(!lp));
`ifdef REG_WRITE_CTRL_FORWARD_EN
        chk("fwd", {31'd0, fwd_hit, fwd_data}, 64'(fwd_model(fwd_addr)));
`endif
      end
    end
  end

  initial begin
    int next_addr;
    model_clear();
    #1;
    tick();
    chk("rst_RegWrite", 64'(reg_write), 64'd0);
    chk("rst_RDaddr", 64'(rd_addr), 64'd0);
    chk("rst_RDdata", 64'(rd_data), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("rst_link_ready", 64'(link_ready), 64'd1);
    rst = 1'b0;
    cmp_on = 1'b1;

    // Single ALU write: accepted at edge 1, visible after edge 2, gone after edge 3.
    alu_valid = 1; alu_addr = 5'd5; alu_data = 32'h1234;
    tick();
    alu_valid = 0;
    tick();
    chk("t1_we", 64'(reg_write), 64'd1);
    chk("t1_addr", 64'(rd_addr), 64'd5);
    chk("t1_data", 64'(rd_data), 64'h1234);
    tick();
    chk("t1_we_off", 64'(reg_write), 64'd0);

    // Link and ALU in the same cycle: link issues first.
    link_valid = 1; link_data = 32'h40;
    alu_valid = 1; alu_addr = 5'd8; alu_data = 32'hAA;
    tick();
    link_valid = 0; alu_valid = 0;
    tick();
    chk("t2_first", {31'd0, reg_write, rd_addr, rd_data}, {31'd0, 1'b1, 5'd31, 32'h40});
    tick();
    chk("t2_second", {31'd0, reg_write, rd_addr, rd_data}, {31'd0, 1'b1, 5'd8, 32'hAA});
    tick();

    // r0 write is dropped: no pulse, address/data hold.
    alu_valid = 1; alu_addr = 5'd0; alu_data = 32'hFFFF;
    tick();
    alu_valid = 0;
    tick();
    chk("t3_we", 64'(reg_write), 64'd0);
    chk("t3_hold", {27'd0, rd_addr, rd_data}, {27'd0, 5'd8, 32'hAA});
    tick();
    chk("t3_we2", 64'(reg_write), 64'd0);

    // Fill: link kept busy so the FIFO grows; ready low after edge 6 only.
    do_reset();
    next_addr = 1;
    link_valid = 1; link_data = 32'h100;
    alu_valid = 1; alu_addr = 5'(next_addr);  alu_data = 32'hA00 + next_addr;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 6) chk("fill_ready_low", 64'(alu_ready), 64'd0);
      if (e == 7) chk("fill_ready_back", 64'(alu_ready), 64'd1);
      if (alu_acc) begin
        next_addr++;
        alu_addr = 5'(next_addr); alu_data = 32'hA00 + next_addr;
      end
      if (link_acc) link_data = link_data + 32'd1;
    end
    link_valid = 0; alu_valid = 0;
    for (int e = 0; e < 8; e++) tick();

    // Reset in mid-stream clears everything immediately.
    for (int e = 0; e < 3; e++) begin
      alu_valid = 1; alu_addr = 5'(10 + e); alu_data = 32'hC0 + e;
      tick();
    end
    alu_valid = 0;
    rst = 1'b1; model_clear();
    #1;
    chk("mid_rst_out", {30'd0, reg_write, rd_addr, rd_data, alu_ready, link_ready},
        {30'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1});
    tick();
    rst = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      chk("post_rst_we", 64'(reg_write), 64'd0);
    end

`ifdef REG_WRITE_CTRL_FORWARD_EN
    // Two writes to r7 pending: youngest wins; r9 misses.
    link_valid = 1; link_data = 32'h55;
    alu_valid = 1; alu_addr = 5'd7; alu_data = 32'h11;
    tick();
    link_valid = 0; alu_addr = 5'd7; alu_data = 32'h22;
    tick();
    alu_valid = 0;
    fwd_addr = 5'd7; #1;
    chk("fwd7", {31'd0, fwd_hit, fwd_data}, {31'd0, 1'b1, 32'h22});
    fwd_addr = 5'd9; #1;
    chk("fwd9", {31'd0, fwd_hit, fwd_data}, 64'd0);
    for (int e = 0; e < 4; e++) tick();
`endif

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        continue;
      end
      if (!alu_valid || alu_acc) begin
        alu_valid = ($urandom_range(0, 99) < 75);
        alu_addr  = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
      end
      if (!link_valid || link_acc) begin
        link_valid = ($urandom_range(0, 99) < 35);
        link_data  = $urandom;
      end
`ifdef REG_WRITE_CTRL_FORWARD_EN
      fwd_addr = 5'($urandom_range(0, 31));
`endif
      tick();
    end

    alu_valid = 0; link_valid = 0;
    for (int e = 0; e < 8; e++) tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
